// File: rtl/hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_unit
//  Purpose  : HI/LO architectural registers plus start/wait sequencing for the
//             iterative divide and multiply units. Issues a one-cycle start,
//             reports busy, captures the 64-bit result, flags divide-by-zero
//             and wait timeouts.
//  Revision : 1.0  initial release
// ============================================================================
module hilo_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_div,
  input  logic        op_mult,
  input  logic        op_mthi,
  input  logic        op_mtlo,
  input  logic [31:0] wr_data,
  output logic        div_start,
  input  logic        div_done,
  input  logic        div_zero,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        mult_start,
  input  logic        mult_done,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        div_zero_exc,
  output logic        timeout_err
);

  // Counter must be able to hold TIMEOUT-1; the extra bit of headroom is harmless.
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START_D = 3'd1,
    START_M = 3'd2,
    WAIT_D  = 3'd3,
    WAIT_M  = 3'd4
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] wait_cnt;
  logic          last_wait;
  logic          cap_div;
  logic          cap_mult;
  logic          zero_evt;
  logic          tmo_evt;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and completion events. Done inputs are only looked at in the
  // WAIT states, so a stale done from the previous operation is absorbed.
  always_comb begin
    next_state = state;
    cap_div    = 1'b0;
    cap_mult   = 1'b0;
    zero_evt   = 1'b0;
    tmo_evt    = 1'b0;
    last_wait  = (wait_cnt == CW'(TIMEOUT - 1));
    case (state)
      IDLE: begin
        if (op_div)       next_state = START_D;
        else if (op_mult) next_state = START_M;
      end
      START_D: next_state = WAIT_D;
      START_M: next_state = WAIT_M;
      WAIT_D: begin
        if (div_done) begin
          next_state = IDLE;
          if (div_zero) zero_evt = 1'b1;
          else          cap_div  = 1'b1;
        end else if (last_wait) begin
          next_state = IDLE;
          tmo_evt    = 1'b1;
        end
      end
      WAIT_M: begin
        if (mult_done) begin
          next_state = IDLE;
          cap_mult   = 1'b1;
        end else if (last_wait) begin
          next_state = IDLE;
          tmo_evt    = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Wait-cycle counter: cleared while starting, counts WAIT cycles without done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == START_D || state == START_M) begin
      wait_cnt <= '0;
    end else if ((state == WAIT_D || state == WAIT_M) && next_state == state) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // HI/LO update: unit results win over mthi/mtlo, which are only honoured in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (cap_div) begin
      hi <= div_hi;
      lo <= div_lo;
    end else if (cap_mult) begin
      hi <= mult_hi;
      lo <= mult_lo;
    end else if (state == IDLE) begin
      if (op_mthi) hi <= wr_data;
      if (op_mtlo) lo <= wr_data;
    end
  end

  // One-cycle exception pulses, registered on the completing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_zero_exc <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      div_zero_exc <= zero_evt;
      timeout_err  <= tmo_evt;
    end
  end

  assign div_start  = (state == START_D);
  assign mult_start = (state == START_M);
  assign busy       = (state != IDLE);

endmodule
`default_nettype wire

// File: doc/hilo_unit.md
# hilo_unit

HI/LO register and multiply/divide sequencing stage for the MIPS datapath. It sits between the control unit and the iterative `div`/`mult` units. It issues the one-cycle start pulse to the selected unit and reports busy so control can stall. On completion it captures the unit's 64-bit result into the architectural HI/LO registers, and it raises a divide-by-zero or timeout event on abnormal completion.

## Interface
- `TIMEOUT`, default 64: maximum cycles spent in a WAIT state before aborting (must be ≥ 40).
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  reset, asynchronous, active-high
- `op_div`  in  1  start signed divide; sampled only in IDLE
- `op_mult`  in  1  start multiply; sampled only in IDLE
- `op_mthi`  in  1  write `wr_data` to HI; sampled only in IDLE
- `op_mtlo`  in  1  write `wr_data` to LO; sampled only in IDLE
- `wr_data`  in  32  write data for mthi/mtlo
- `div_start`  out  1  drives the divider's start input
- `div_done`  in  1  divider finished (level, may stay high ≥2 cycles)
- `div_zero`  in  1  divider flagged divisor = 0; valid with `div_done`
- `div_hi`, `div_lo`  in  32 each  remainder, quotient
- `mult_start`  out  1  drives multiplier start
- `mult_done`  in  1  multiplier finished (level)
- `mult_hi`, `mult_lo`  in  32 each  product upper/lower word
- `hi`, `lo`  out  32 each  architectural HI/LO (mfhi/mflo read these directly)
- `busy`  out  1  high whenever state ≠ IDLE
- `div_zero_exc`  out  1  one-cycle pulse on divide-by-zero completion
- `timeout_err`  out  1  one-cycle pulse on WAIT timeout

## Operation
- States: IDLE, START_D, START_M, WAIT_D, WAIT_M.
- IDLE:
  - `op_div` → START_D.
  - Else `op_mult` → START_M.
  - `op_div` has priority when both are high.
- `op_mthi`/`op_mtlo` in IDLE write HI/LO at that edge. Both may assert together.
  - Legal in the same cycle as `op_div`/`op_mult`; the later result overwrites.
- START_D asserts `div_start` for exactly one cycle, then → WAIT_D. START_M/`mult_start` behave the same way → WAIT_M.
- `*_done` is ignored in START states. This absorbs a stale `done` from the previous operation.
- WAIT_D, `div_done`=1:
  - `div_zero`=0: HI←`div_hi`, LO←`div_lo`.
  - `div_zero`=1: HI/LO unchanged, `div_zero_exc` pulses.
  - Either case → IDLE.
- WAIT_M, `mult_done`=1: HI←`mult_hi`, LO←`mult_lo` → IDLE.
- Capture happens once per operation. A `done` that remains high after the return to IDLE has no effect.
- Timeout counter:
  - Cleared on WAIT entry; increments each WAIT cycle without `done`.
  - On reaching `TIMEOUT`: `timeout_err` pulses, HI/LO unchanged → IDLE.
- All `op_*` inputs while `busy`=1 are dropped; HI/LO are unchanged. Control must stall on `busy`.
- No arithmetic is performed here. Results are stored bit-exact (sign handling is the producer's job).

## Timing
- Reset (async, any state, mid-operation included): state IDLE; `hi`=`lo`=0; `div_start`=`mult_start`=`busy`=`div_zero_exc`=`timeout_err`=0; counter 0.
- `div_start`, `mult_start`, `busy`, `div_zero_exc`, `timeout_err` are registered-state (Moore) outputs.
- Divide start sequence:
  - `op_div` sampled at edge N.
  - START_D (`div_start`=1, `busy`=1) during cycle N..N+1.
  - WAIT_D from edge N+1.
  - The divider samples start at edge N+1.
- Capture edge: first rising edge in WAIT with `done`=1.
  - `hi`/`lo` are updated after that edge.
  - `busy` falls in the same cycle.
  - `div_zero_exc` is high for the cycle following that edge only.
- mthi/mtlo: `hi`/`lo` visible the cycle after the sampling edge; zero added latency.
- Back-to-back operations: a new op is accepted on the first edge where `busy`=0.

## Test plan
- Divider stub, A=7, B=2, done after 33 cycles with hi=1, lo=3 → `div_start` one cycle; `busy` high until capture; then `hi`=1, `lo`=3.
- Stub returns hi=0xFFFFFFFF, lo=0xFFFFFFFD (−7/2) with `div_done` held 2 cycles → captured once, state IDLE, `busy`=0.
- Preload mthi 0xDEADBEEF / mtlo 0x12345678, then divide with `div_zero`=1 → `div_zero_exc` one-cycle pulse; `hi`/`lo` remain 0xDEADBEEF/0x12345678.
- Mult stub returns 0x00000001_80000000; `op_mthi` issued while busy → `hi`=0x00000001, `lo`=0x80000000; mthi dropped.
- `op_div` with stub never asserting done, `TIMEOUT`=64 → `timeout_err` pulse after 64 WAIT cycles; `hi`/`lo` unchanged; IDLE.
- Reset asserted mid-WAIT_D → immediately IDLE with all outputs 0. A later `div_done` pulse is ignored, and a fresh divide completes normally.
